// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates the shared TLB lookup port between I-side and D-side MMUs and serialises CP0 maintenance.
// Latency: request cycle 0, tlb_req from cycle 1, x_rdy one cycle after tlb_ack (minimum 2); requesters hold x_en until x_rdy.
module tlb_lookup_arbiter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_en,
    input  logic [AW-1:0] i_vaddr,
    output logic          i_rdy,
    input  logic          d_en,
    input  logic [AW-1:0] d_vaddr,
    input  logic          d_refs,
    output logic          d_rdy,
    output logic [AW-1:0] r_paddr,
    output logic          r_cat,
    output logic          r_tlbr,
    output logic          r_tlbi,
    output logic          r_tlbm,
    output logic          tlb_req,
    output logic [AW-1:0] tlb_vaddr,
    output logic          tlb_refs,
    input  logic          tlb_ack,
    input  logic [AW-1:0] tlb_paddr,
    input  logic          tlb_cat,
    input  logic          tlb_tlbr,
    input  logic          tlb_tlbi,
    input  logic          tlb_tlbm,
    input  logic          m_req,
    output logic          m_gnt
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, RESP} state_t;

    state_t state, state_nxt;
    logic   last_d;
    logic   abort;
    logic   in_wait;
    logic   grant_i;
    logic   grant_d;
    logic   drop_result;

    // Maintenance outranks lookups; on a double request the side not served last wins.
    always_comb begin
        in_wait     = (state == WAIT_I) || (state == WAIT_D);
        grant_d     = (state == IDLE) && !m_req && !flush && d_en && (!i_en || !last_d);
        grant_i     = (state == IDLE) && !m_req && !flush && i_en && (!d_en || last_d);
        drop_result = abort || flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = WAIT_D;
                end else if (grant_i) begin
                    state_nxt = WAIT_I;
                end
            end
            WAIT_I, WAIT_D: begin
                if (tlb_ack) begin
                    state_nxt = drop_result ? IDLE : RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tlb_req = in_wait;
        m_gnt   = (state == IDLE) && m_req;
        i_rdy   = (state == RESP) && !last_d && i_en && !flush && !abort;
        d_rdy   = (state == RESP) && last_d && d_en && !flush && !abort;
    end

    // A flushed lookup still completes its TLB handshake; abort only suppresses the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d    <= 1'b0;
            abort     <= 1'b0;
            tlb_vaddr <= '0;
            tlb_refs  <= 1'b0;
            r_paddr   <= '0;
            r_cat     <= 1'b0;
            r_tlbr    <= 1'b0;
            r_tlbi    <= 1'b0;
            r_tlbm    <= 1'b0;
        end else begin
            if (grant_d || grant_i) begin
                tlb_vaddr <= grant_d ? d_vaddr : i_vaddr;
                tlb_refs  <= grant_d && d_refs;
                last_d    <= grant_d;
            end
            if (state_nxt == IDLE) begin
                abort <= 1'b0;
            end else if (in_wait && flush) begin
                abort <= 1'b1;
            end
            if (in_wait && tlb_ack && !drop_result) begin
                r_paddr <= tlb_paddr;
                r_cat   <= tlb_cat;
                r_tlbr  <= tlb_tlbr;
                r_tlbi  <= tlb_tlbi;
                r_tlbm  <= tlb_tlbm;
            end
        end
    end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Directed scenarios followed by randomized traffic against a transaction-level model of the arbiter.
module tb_tlb_lookup_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst, flush, i_en, d_en, d_refs, m_req;
    logic [AW-1:0] i_vaddr, d_vaddr;
    logic          tlb_ack, tlb_cat, tlb_tlbr, tlb_tlbi, tlb_tlbm;
    logic [AW-1:0] tlb_paddr;
    logic          i_rdy, d_rdy, r_cat, r_tlbr, r_tlbi, r_tlbm, tlb_req, tlb_refs, m_gnt;
    logic [AW-1:0] r_paddr, tlb_vaddr;

    int total = 0;
    int bad   = 0;

    tlb_lookup_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_en(i_en), .i_vaddr(i_vaddr), .i_rdy(i_rdy),
        .d_en(d_en), .d_vaddr(d_vaddr), .d_refs(d_refs), .d_rdy(d_rdy),
        .r_paddr(r_paddr), .r_cat(r_cat), .r_tlbr(r_tlbr), .r_tlbi(r_tlbi), .r_tlbm(r_tlbm),
        .tlb_req(tlb_req), .tlb_vaddr(tlb_vaddr), .tlb_refs(tlb_refs),
        .tlb_ack(tlb_ack), .tlb_paddr(tlb_paddr), .tlb_cat(tlb_cat),
        .tlb_tlbr(tlb_tlbr), .tlb_tlbi(tlb_tlbi), .tlb_tlbm(tlb_tlbm),
        .m_req(m_req), .m_gnt(m_gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic ack_on(input logic [31:0] pa, input logic c, input logic r, input logic i, input logic m);
        tlb_ack = 1'b1; tlb_paddr = pa; tlb_cat = c; tlb_tlbr = r; tlb_tlbi = i; tlb_tlbm = m;
    endtask

    task automatic ack_off();
        tlb_ack = 1'b0; tlb_paddr = '0; tlb_cat = 1'b0; tlb_tlbr = 1'b0; tlb_tlbi = 1'b0; tlb_tlbm = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, ".i_rdy"}, i_rdy, 1'b0);
        chk1({tag, ".d_rdy"}, d_rdy, 1'b0);
        chk1({tag, ".tlb_req"}, tlb_req, 1'b0);
        chk1({tag, ".m_gnt"}, m_gnt, 1'b0);
        chk({tag, ".r_paddr"}, r_paddr, 32'h0);
        chk({tag, ".tlb_vaddr"}, tlb_vaddr, 32'h0);
        chk1({tag, ".tlb_refs"}, tlb_refs, 1'b0);
        chk1({tag, ".r_flags"}, r_cat | r_tlbr | r_tlbi | r_tlbm, 1'b0);
    endtask

    // Reference TLB contents used by the randomized phase.
    function automatic logic [31:0] map_pa(input logic [31:0] v);
        return {v[31:12] ^ 20'hA5C3F, v[11:0]};
    endfunction

    // Transaction-level model state for the random phase.
    bit            pi, pd, pm, rd;
    logic [31:0]   ai, ad;
    bit            mw, mr, ms, mlast, mref, idle, grant, side, next_mr;
    logic [31:0]   maddr;
    int            cnt;

    initial begin
        rst = 1'b1; flush = 1'b0; i_en = 1'b0; d_en = 1'b0; d_refs = 1'b0; m_req = 1'b0;
        i_vaddr = '0; d_vaddr = '0;
        ack_off();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mid();
        chk_all_zero("reset");

        // D-only lookup with ack at cycle 3.
        nxt(); d_en = 1'b1; d_vaddr = 32'h0040_1000; mid();
        chk1("t1.c0.tlb_req", tlb_req, 1'b0);
        nxt(); mid();
        chk1("t1.c1.tlb_req", tlb_req, 1'b1);
        chk("t1.c1.tlb_vaddr", tlb_vaddr, 32'h0040_1000);
        nxt(); mid();
        chk1("t1.c2.tlb_req", tlb_req, 1'b1);
        nxt(); ack_on(32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0); mid();
        chk1("t1.c3.tlb_req", tlb_req, 1'b1);
        chk1("t1.c3.d_rdy", d_rdy, 1'b0);
        nxt(); ack_off(); mid();
        chk1("t1.c4.d_rdy", d_rdy, 1'b1);
        chk1("t1.c4.i_rdy", i_rdy, 1'b0);
        chk1("t1.c4.tlb_req", tlb_req, 1'b0);
        chk("t1.c4.r_paddr", r_paddr, 32'h0000_1000);
        chk1("t1.c4.r_cat", r_cat, 1'b1);
        nxt(); d_en = 1'b0; mid();
        chk1("t1.c5.d_rdy", d_rdy, 1'b0);
        chk("t1.c5.r_paddr_hold", r_paddr, 32'h0000_1000);

        // Reset while waiting on the TLB for a D lookup.
        nxt(); d_en = 1'b1; d_vaddr = 32'h1234_5000; mid();
        nxt(); mid();
        chk1("t6.wait.tlb_req", tlb_req, 1'b1);
        nxt(); rst = 1'b1; d_en = 1'b0; mid();
        nxt(); rst = 1'b0; mid();
        chk_all_zero("t6.after_rst");
        nxt(); m_req = 1'b1; mid();
        chk1("t6.idle.m_gnt", m_gnt, 1'b1);
        nxt(); m_req = 1'b0; mid();

        // Simultaneous requests alternate D, I, then D again.
        nxt(); i_en = 1'b1; i_vaddr = 32'h0000_A000; d_en = 1'b1; d_vaddr = 32'h0000_B000; mid();
        chk1("t2.c0.tlb_req", tlb_req, 1'b0);
        nxt(); ack_on(32'h0B00_0000, 1'b0, 1'b0, 1'b0, 1'b0); mid();
        chk("t2.first.tlb_vaddr", tlb_vaddr, 32'h0000_B000);
        nxt(); ack_off(); mid();
        chk1("t2.first.d_rdy", d_rdy, 1'b1);
        chk1("t2.first.i_rdy", i_rdy, 1'b0);
        chk("t2.first.r_paddr", r_paddr, 32'h0B00_0000);
        nxt(); d_en = 1'b0; mid();
        chk1("t2.idle.tlb_req", tlb_req, 1'b0);
        nxt(); ack_on(32'h0A00_0000, 1'b1, 1'b0, 1'b0, 1'b0); mid();
        chk("t2.second.tlb_vaddr", tlb_vaddr, 32'h0000_A000);
        nxt(); ack_off(); mid();
        chk1("t2.second.i_rdy", i_rdy, 1'b1);
        chk1("t2.second.d_rdy", d_rdy, 1'b0);
        chk("t2.second.r_paddr", r_paddr, 32'h0A00_0000);
        nxt(); i_vaddr = 32'h0000_C000; d_en = 1'b1; d_vaddr = 32'h0000_D000; mid();
        nxt(); ack_on(32'h0D00_0000, 1'b0, 1'b0, 1'b0, 1'b0); mid();
        chk("t2.third.tlb_vaddr", tlb_vaddr, 32'h0000_D000);
        nxt(); ack_off(); mid();
        chk1("t2.third.d_rdy", d_rdy, 1'b1);
        nxt(); d_en = 1'b0; mid();
        nxt(); ack_on(32'h0C00_0000, 1'b0, 1'b0, 1'b0, 1'b0); mid();
        nxt(); ack_off(); mid();
        chk1("t2.fourth.i_rdy", i_rdy, 1'b1);
        nxt(); i_en = 1'b0; mid();

        // Maintenance beats a lookup in IDLE and waits for a lookup in flight.
        nxt(); m_req = 1'b1; d_en = 1'b1; d_vaddr = 32'h0000_E000; mid();
        chk1("t3.c0.m_gnt", m_gnt, 1'b1);
        chk1("t3.c0.tlb_req", tlb_req, 1'b0);
        nxt(); m_req = 1'b0; mid();
        chk1("t3.c1.m_gnt", m_gnt, 1'b0);
        chk1("t3.c1.tlb_req", tlb_req, 1'b0);
        nxt(); m_req = 1'b1; mid();
        chk1("t3.wait.tlb_req", tlb_req, 1'b1);
        chk1("t3.wait.m_gnt", m_gnt, 1'b0);
        nxt(); ack_on(32'h0E00_0000, 1'b0, 1'b0, 1'b0, 1'b0); mid();
        chk1("t3.ack.m_gnt", m_gnt, 1'b0);
        nxt(); ack_off(); mid();
        chk1("t3.resp.d_rdy", d_rdy, 1'b1);
        chk1("t3.resp.m_gnt", m_gnt, 1'b0);
        nxt(); d_en = 1'b0; mid();
        chk1("t3.after.m_gnt", m_gnt, 1'b1);
        nxt(); m_req = 1'b0; mid();

        // Store hitting a clean page, then an I-side lookup.
        nxt(); d_en = 1'b1; d_refs = 1'b1; d_vaddr = 32'h0000_F000; mid();
        nxt(); ack_on(32'h0F00_0000, 1'b0, 1'b0, 1'b0, 1'b1); mid();
        chk1("t5.store.tlb_refs", tlb_refs, 1'b1);
        nxt(); ack_off(); mid();
        chk1("t5.store.d_rdy", d_rdy, 1'b1);
        chk1("t5.store.r_tlbm", r_tlbm, 1'b1);
        nxt(); d_en = 1'b0; d_refs = 1'b0; i_en = 1'b1; i_vaddr = 32'h0001_0000; mid();
        nxt(); ack_on(32'h0100_0000, 1'b0, 1'b1, 1'b1, 1'b0); mid();
        chk1("t5.ifetch.tlb_refs", tlb_refs, 1'b0);
        chk("t5.ifetch.tlb_vaddr", tlb_vaddr, 32'h0001_0000);
        nxt(); ack_off(); mid();
        chk1("t5.ifetch.i_rdy", i_rdy, 1'b1);
        chk1("t5.ifetch.r_tlbr", r_tlbr, 1'b1);
        chk1("t5.ifetch.r_tlbi", r_tlbi, 1'b1);
        chk1("t5.ifetch.r_tlbm", r_tlbm, 1'b0);
        nxt(); i_en = 1'b0; mid();

        // Flush while waiting on an I lookup: no response, next request accepted right away.
        nxt(); i_en = 1'b1; i_vaddr = 32'h0002_0000; mid();
        nxt(); flush = 1'b1; mid();
        chk1("t4.flush.tlb_req", tlb_req, 1'b1);
        nxt(); flush = 1'b0; mid();
        chk1("t4.held.tlb_req", tlb_req, 1'b1);
        nxt(); ack_on(32'h0200_0000, 1'b1, 1'b0, 1'b0, 1'b0); mid();
        nxt(); ack_off(); mid();
        chk1("t4.post.i_rdy", i_rdy, 1'b0);
        chk1("t4.post.tlb_req", tlb_req, 1'b0);
        nxt(); mid();
        chk1("t4.regrant.tlb_req", tlb_req, 1'b1);
        chk("t4.regrant.tlb_vaddr", tlb_vaddr, 32'h0002_0000);
        nxt(); ack_on(32'h0200_0000, 1'b1, 1'b0, 1'b0, 1'b0); mid();
        nxt(); ack_off(); mid();
        chk1("t4.regrant.i_rdy", i_rdy, 1'b1);
        nxt(); i_en = 1'b0; rst = 1'b1; mid();
        nxt(); rst = 1'b0;

        // Randomized traffic: requesters hold en until rdy, TLB answers after 0..3 wait cycles.
        pi = 0; pd = 0; pm = 0; rd = 0; ai = '0; ad = '0;
        mw = 0; mr = 0; ms = 0; mlast = 0; mref = 0; maddr = '0; cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!pi && $urandom_range(0, 3) == 0) begin pi = 1; ai = $urandom; end
            if (!pd && $urandom_range(0, 3) == 0) begin pd = 1; ad = $urandom; rd = 1'($urandom_range(0, 1)); end
            if (!pm && $urandom_range(0, 9) == 0) pm = 1;
            i_en = pi; i_vaddr = ai; d_en = pd; d_vaddr = ad; d_refs = rd; m_req = pm;
            if (mw && cnt == 0) begin
                ack_on(map_pa(maddr), maddr[20], maddr[21], maddr[22], maddr[23]);
            end else begin
                tlb_ack = 1'b0; tlb_paddr = $urandom;
                tlb_cat = 1'($urandom_range(0, 1)); tlb_tlbr = 1'($urandom_range(0, 1));
                tlb_tlbi = 1'($urandom_range(0, 1)); tlb_tlbm = 1'($urandom_range(0, 1));
            end
            mid();
            idle = !mw && !mr;
            chk1("rnd.tlb_req", tlb_req, mw);
            if (mw) begin
                chk("rnd.tlb_vaddr", tlb_vaddr, maddr);
                chk1("rnd.tlb_refs", tlb_refs, mref);
            end
            chk1("rnd.i_rdy", i_rdy, mr && !ms);
            chk1("rnd.d_rdy", d_rdy, mr && ms);
            if (mr) begin
                chk("rnd.r_paddr", r_paddr, map_pa(maddr));
                chk("rnd.r_flags", {28'h0, r_cat, r_tlbr, r_tlbi, r_tlbm},
                    {28'h0, maddr[20], maddr[21], maddr[22], maddr[23]});
            end
            chk1("rnd.m_gnt", m_gnt, idle && pm);
            grant = idle && !pm && (pi || pd);
            side  = (pi && pd) ? !mlast : pd;
            if (mr) begin
                if (ms) pd = 0; else pi = 0;
            end
            if (idle && pm) pm = 0;
            next_mr = 0;
            if (mw) begin
                if (cnt == 0) begin mw = 0; next_mr = 1; end
                else cnt--;
            end else if (grant) begin
                mlast = side; ms = side; maddr = side ? ad : ai; mref = side && rd;
                mw = 1; cnt = $urandom_range(0, 3);
            end
            mr = next_mr;
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
